// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_pc_sel and fetch_sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam int unsigned PC_STEP      = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [1:0]  ALIGN_MASK   = 2'b11;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC mux: hold, sequential step, or word-aligned redirect target.
// Purely combinational; the PC register lives in fetch_sequencer.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] target_pc,
  output logic [ADDR_W-1:0] next_pc
);

  assign target_pc = redirect_pc & ~ADDR_W'(ALIGN_MASK);

  // A redirect always wins over the sequential step.
  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = target_pc;
    end else if (advance) begin
      next_pc = pc + ADDR_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one memory request at a time and
// hands each returned word to decode over a valid/ready handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state;
  logic              advance;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] next_pc;

  assign advance = (state == WAIT) && mem_ack;

  fetch_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_pc_sel (
    .pc            (pc),
    .advance       (advance),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .target_pc     (target_pc),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      pc <= next_pc;
      unique case (state)
        IDLE: begin
          mem_req  <= 1'b1;
          mem_addr <= redirect_valid ? target_pc : pc;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (redirect_valid) begin
              state <= IDLE;
            end else begin
              instr       <= mem_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            // Request stays on the bus at the old address until acked.
            state <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + CNT_W'(1);
          end
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
            state       <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00 ^ {a[15:0], a[31:16]};
  endfunction

  assign mem_data = memf(mem_addr);

  fetch_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(32'h0000_0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_total++;
    if ({mem_req, instr_valid, mem_addr} !== '0)
      $display("FAIL rst_req got=%h exp=0", {mem_req, instr_valid, mem_addr});
    else n_pass++;
    n_total++;
    if ({instr, instr_pc} !== '0)
      $display("FAIL rst_instr got=%h exp=0", {instr, instr_pc});
    else n_pass++;
    n_total++;
    if ({pc, fetch_count} !== '0)
      $display("FAIL rst_pc_cnt got=%h exp=0", {pc, fetch_count});
    else n_pass++;
  endtask

  task automatic test_streaming;
    logic [31:0] a;
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      a = 32'(4 * (i / 2));
      n_total++;
      if (i % 2 == 0) begin
        if ({mem_req, mem_addr} !== {1'b1, a})
          $display("FAIL stream_req i=%0d got=%h exp=%h", i, {mem_req, mem_addr}, {1'b1, a});
        else n_pass++;
      end else begin
        if ({instr_valid, instr_pc, instr} !== {1'b1, a, memf(a)})
          $display("FAIL stream_instr i=%0d got=%h exp=%h", i,
                   {instr_valid, instr_pc, instr}, {1'b1, a, memf(a)});
        else n_pass++;
      end
    end
    tick();
    n_total++;
    if ({fetch_count, mem_req, mem_addr} !== {CNT_W'(4), 1'b1, 32'd16})
      $display("FAIL stream_count got=%h exp=%h",
               {fetch_count, mem_req, mem_addr}, {CNT_W'(4), 1'b1, 32'd16});
    else n_pass++;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_decode_stall;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_total++;
    if ({instr_valid, instr_pc, pc} !== {1'b1, 32'd16, 32'd20})
      $display("FAIL stall_enter got=%h exp=%h",
               {instr_valid, instr_pc, pc}, {1'b1, 32'd16, 32'd20});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if ({instr_valid, mem_req, instr, pc} !== {1'b1, 1'b0, memf(32'd16), 32'd20})
        $display("FAIL stall_hold k=%0d got=%h exp=%h", k,
                 {instr_valid, mem_req, instr, pc}, {1'b1, 1'b0, memf(32'd16), 32'd20});
      else n_pass++;
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, instr_valid, fetch_count} !== {1'b1, 32'd20, 1'b0, CNT_W'(5)})
      $display("FAIL stall_release got=%h exp=%h",
               {mem_req, mem_addr, instr_valid, fetch_count},
               {1'b1, 32'd20, 1'b0, CNT_W'(5)});
    else n_pass++;
  endtask

  task automatic test_slow_memory;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'd20, 1'b0})
        $display("FAIL slow_wait k=%0d got=%h exp=%h", k,
                 {mem_req, mem_addr, instr_valid}, {1'b1, 32'd20, 1'b0});
      else n_pass++;
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_total++;
    if ({instr_valid, mem_req, instr_pc, instr} !== {1'b1, 1'b0, 32'd20, memf(32'd20)})
      $display("FAIL slow_ack got=%h exp=%h", {instr_valid, mem_req, instr_pc, instr},
               {1'b1, 1'b0, 32'd20, memf(32'd20)});
    else n_pass++;
  endtask

  task automatic test_redirect_wait;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    tick();
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, pc, instr_valid} !== {1'b1, 32'h8, 32'h100, 1'b0})
      $display("FAIL rw_drop got=%h exp=%h", {mem_req, mem_addr, pc, instr_valid},
               {1'b1, 32'h8, 32'h100, 1'b0});
    else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_total++;
    if ({mem_req, instr_valid} !== 2'b00)
      $display("FAIL rw_discard got=%b exp=00", {mem_req, instr_valid});
    else n_pass++;
    tick();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h100})
      $display("FAIL rw_target got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h100});
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, pc} !== {1'b1, 32'h100, 32'h200})
      $display("FAIL rw_last_wins got=%h exp=%h", {mem_req, mem_addr, pc},
               {1'b1, 32'h100, 32'h200});
    else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    n_total++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h200, 1'b0})
      $display("FAIL rw_second got=%h exp=%h", {mem_req, mem_addr, instr_valid},
               {1'b1, 32'h200, 1'b0});
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h280;
    mem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    mem_ack = 1'b0;
    n_total++;
    if ({mem_req, instr_valid, pc} !== {1'b0, 1'b0, 32'h280})
      $display("FAIL rw_ack_redir got=%h exp=%h", {mem_req, instr_valid, pc},
               {1'b0, 1'b0, 32'h280});
    else n_pass++;
    tick();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h280})
      $display("FAIL rw_penalty got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h280});
    else n_pass++;
  endtask

  task automatic test_redirect_hold;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if ({instr_valid, pc, fetch_count} !== {1'b0, 32'h100, CNT_W'(0)})
      $display("FAIL rh_squash got=%h exp=%h", {instr_valid, pc, fetch_count},
               {1'b0, 32'h100, CNT_W'(0)});
    else n_pass++;
    tick();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h100})
      $display("FAIL rh_align got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h100});
    else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    n_total++;
    if ({instr_valid, mem_req, pc, fetch_count} !== {1'b0, 1'b0, 32'h40, CNT_W'(1)})
      $display("FAIL rh_accept got=%h exp=%h", {instr_valid, mem_req, pc, fetch_count},
               {1'b0, 1'b0, 32'h40, CNT_W'(1)});
    else n_pass++;
    tick();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40})
      $display("FAIL rh_target got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h40});
    else n_pass++;
  endtask

  task automatic test_wrap;
    int  acc;
    logic seen;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    n_total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_top got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'hFFFF_FFFC});
    else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_total++;
    if ({instr_valid, instr_pc, pc} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_pc got=%h exp=%h", {instr_valid, instr_pc, pc},
               {1'b1, 32'hFFFF_FFFC, 32'h0});
    else n_pass++;
    instr_ready = 1'b1;
    tick();
    n_total++;
    if ({mem_req, mem_addr, fetch_count} !== {1'b1, 32'h0, CNT_W'(2)})
      $display("FAIL wrap_next got=%h exp=%h", {mem_req, mem_addr, fetch_count},
               {1'b1, 32'h0, CNT_W'(2)});
    else n_pass++;
    acc = 2;
    seen = 1'b0;
    mem_ack = 1'b1;
    for (int k = 0; k < 2000 && acc < 256; k++) begin
      if (instr_valid && instr_ready) acc++;
      tick();
      if (acc == 255 && !seen) begin
        seen = 1'b1;
        n_total++;
        if (fetch_count !== CNT_W'(255))
          $display("FAIL cnt_max got=%h exp=%h", fetch_count, CNT_W'(255));
        else n_pass++;
      end
    end
    n_total++;
    if (acc != 256 || fetch_count !== CNT_W'(0))
      $display("FAIL cnt_wrap got=%h exp=0 accepts=%0d", fetch_count, acc);
    else n_pass++;
    mem_ack = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    tick();
    n_total++;
    if ({mem_req, instr_valid} !== 2'b10)
      $display("FAIL mid_pre got=%b exp=10", {mem_req, instr_valid});
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, instr_valid, instr, instr_pc, pc, fetch_count} !== '0)
      $display("FAIL mid_reset got=%h exp=0",
               {mem_req, mem_addr, instr_valid, instr, instr_pc, pc, fetch_count});
    else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL mid_idle_ack got=%h exp=%h", {mem_req, mem_addr, instr_valid},
               {1'b1, 32'h0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] p_addr, p_pc, p_instr;
    logic p_req, p_ack, p_valid, p_ready, p_rv, p_dlv, killed, dlv, fresh;
    int acc;
    do_reset();
    exp_pc = 32'h0;
    acc = 0;
    {p_req, p_ack, p_valid, p_ready, p_rv, p_dlv, killed} = '0;
    p_addr = '0;
    p_pc = '0;
    p_instr = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!p_req) killed = 1'b0;
      fresh = instr_valid && !p_valid;
      n_total++;
      if (fresh !== p_dlv)
        $display("FAIL rnd_deliver cyc=%0d got=%b exp=%b", i, fresh, p_dlv);
      else n_pass++;
      if (fresh) begin
        n_total++;
        if ({instr_pc, instr} !== {exp_pc, memf(exp_pc)})
          $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, {instr_pc, instr},
                   {exp_pc, memf(exp_pc)});
        else n_pass++;
      end
      if (p_req && !p_ack) begin
        n_total++;
        if ({mem_req, mem_addr} !== {1'b1, p_addr})
          $display("FAIL rnd_req_stable cyc=%0d got=%h exp=%h", i, {mem_req, mem_addr},
                   {1'b1, p_addr});
        else n_pass++;
      end
      if (p_valid && !p_ready && !p_rv) begin
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, p_pc, p_instr})
          $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", i, {instr_valid, instr_pc, instr},
                   {1'b1, p_pc, p_instr});
        else n_pass++;
      end
      n_total++;
      if (fetch_count !== CNT_W'(acc))
        $display("FAIL rnd_count cyc=%0d got=%h exp=%h", i, fetch_count, CNT_W'(acc));
      else n_pass++;
      n_total++;
      if ((instr_valid & mem_req) !== 1'b0)
        $display("FAIL rnd_overlap cyc=%0d got=%b exp=0", i, instr_valid & mem_req);
      else n_pass++;
      mem_ack = ($urandom_range(0, 9) < 5);
      instr_ready = ($urandom_range(0, 9) < 5);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom;
      dlv = mem_req && mem_ack && !redirect_valid && !killed;
      if (instr_valid && instr_ready) acc++;
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      if (mem_req && redirect_valid) killed = 1'b1;
      p_req = mem_req;
      p_addr = mem_addr;
      p_valid = instr_valid;
      p_pc = instr_pc;
      p_instr = instr;
      p_ack = mem_ack;
      p_ready = instr_ready;
      p_rv = redirect_valid;
      p_dlv = dlv;
      tick();
    end
    mem_ack = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_decode_stall();
    test_slow_memory();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
